// File: rtl/irq_edge_controller.sv
// Edge-triggered, fixed-priority interrupt controller with nested in-service
// tracking and an INTR/INTA/EOI handshake toward the CPU core.
module irq_edge_controller #(
  parameter int NUM_IRQS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQS-1:0] irq_lines,
  input  logic [NUM_IRQS-1:0] mask,
  input  logic [7:0]          vector_base,
  input  logic                inta,
  input  logic                eoi,
  output logic                intr,
  output logic [7:0]          vector,
  output logic                vector_valid,
  output logic [NUM_IRQS-1:0] pending,
  output logic [NUM_IRQS-1:0] in_service
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    VECTOR = 2'd2
  } state_e;

  state_e              state_q;
  logic                intr_q;
  logic [7:0]          vector_q;
  logic                vector_valid_q;
  logic [NUM_IRQS-1:0] prev_q;
  logic [NUM_IRQS-1:0] pending_q, pending_d;
  logic [NUM_IRQS-1:0] isr_q, isr_d;

  logic [NUM_IRQS-1:0] edge_det;
  logic [NUM_IRQS-1:0] below_top;
  logic [NUM_IRQS-1:0] top_onehot;
  logic [NUM_IRQS-1:0] eligible;
  logic [NUM_IRQS-1:0] win_onehot;
  logic [2:0]          winner;
  logic                any_eligible;
  logic                ack;
  logic                seen;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    edge_det   = irq_lines & ~prev_q;
    seen       = 1'b0;
    top_onehot = '0;
    below_top  = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      top_onehot[i] = isr_q[i] & ~seen;
      seen          = seen | isr_q[i];
      below_top[i]  = ~seen;
    end

    // Only requests of strictly higher priority than the active service nest.
    eligible     = pending_q & ~mask & below_top;
    any_eligible = |eligible;
    winner       = 3'd0;
    win_onehot   = '0;
    for (int i = NUM_IRQS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner        = 3'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end

    ack       = (state_q == REQ) && inta && any_eligible;
    // A new edge on a line being acknowledged re-latches it.
    pending_d = (pending_q & ~({NUM_IRQS{ack}} & win_onehot)) | edge_det;
    isr_d     = (isr_q | ({NUM_IRQS{ack}} & win_onehot))
                & ~({NUM_IRQS{eoi}} & top_onehot);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '1;
      pending_q <= '0;
      isr_q     <= '0;
    end else begin
      prev_q    <= irq_lines;
      pending_q <= pending_d;
      isr_q     <= isr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      intr_q         <= 1'b0;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
    end else begin
      vector_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_eligible) begin
            state_q <= REQ;
            intr_q  <= 1'b1;
          end
        end
        REQ: begin
          if (inta) begin
            // With nothing eligible at acknowledge time, hand out the spurious slot 7.
            state_q        <= VECTOR;
            intr_q         <= 1'b0;
            vector_valid_q <= 1'b1;
            vector_q       <= {vector_base[7:3], any_eligible ? winner : 3'd7};
          end else if (!any_eligible) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
          end
        end
        VECTOR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign intr         = intr_q;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign pending      = pending_q;
  assign in_service   = isr_q;

endmodule

// File: tb/tb_irq_edge_controller.sv
// Directed bench for irq_edge_controller; acknowledged vectors are checked
// against a queue of expected values filled when each inta is driven.
module tb_irq_edge_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_lines;
  logic [7:0] mask;
  logic [7:0] vector_base;
  logic       inta;
  logic       eoi;
  logic       intr;
  logic [7:0] vector;
  logic       vector_valid;
  logic [7:0] pending;
  logic [7:0] in_service;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  irq_edge_controller #(.NUM_IRQS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_lines    (irq_lines),
    .mask         (mask),
    .vector_base  (vector_base),
    .inta         (inta),
    .eoi          (eoi),
    .intr         (intr),
    .vector       (vector),
    .vector_valid (vector_valid),
    .pending      (pending),
    .in_service   (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack(input logic [7:0] exp_vec);
    exp_q.push_back(exp_vec);
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  // Scoreboard consumer: every vector strobe must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (vector_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL vv_unexpected: observed strobe with vector %02h expected none", vector);
      end else begin
        check("vector", vector, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset       = 1'b1;
    irq_lines   = 8'h80;
    mask        = 8'h00;
    vector_base = 8'h0D;
    inta        = 1'b0;
    eoi         = 1'b0;
    tick(2);
    check("rst_intr", 8'(intr), 8'h00);
    check("rst_vv", 8'(vector_valid), 8'h00);
    check("rst_vector", vector, 8'h00);
    check("rst_pending", pending, 8'h00);
    check("rst_isr", in_service, 8'h00);

    // Line 7 held high through reset must not request.
    reset = 1'b0;
    tick(3);
    check("held_pending", pending, 8'h00);
    check("held_intr", 8'(intr), 8'h00);
    irq_lines = 8'h00;
    tick();

    // Single request on line 3; bits [2:0] of the base are ignored.
    irq_lines = 8'h08;
    tick();
    irq_lines = 8'h00;
    check("l3_pending", pending, 8'h08);
    check("l3_intr_early", 8'(intr), 8'h00);
    tick();
    check("l3_intr", 8'(intr), 8'h01);
    do_ack(8'h0B);
    check("l3_ack_intr", 8'(intr), 8'h00);
    check("l3_ack_vv", 8'(vector_valid), 8'h01);
    check("l3_isr", in_service, 8'h08);
    check("l3_pend_clr", pending, 8'h00);
    tick();
    check("l3_vv_drop", 8'(vector_valid), 8'h00);
    check("l3_vec_hold", vector, 8'h0B);
    do_eoi();
    check("l3_eoi_isr", in_service, 8'h00);

    // inta in IDLE is ignored.
    inta = 1'b1;
    tick();
    inta = 1'b0;
    check("idle_inta_vv", 8'(vector_valid), 8'h00);
    check("idle_inta_isr", in_service, 8'h00);
    check("idle_inta_intr", 8'(intr), 8'h00);

    // Simultaneous edges on 5 and 2: 2 first, 5 only after its EOI.
    irq_lines = 8'h24;
    tick();
    irq_lines = 8'h00;
    check("dual_pending", pending, 8'h24);
    tick();
    check("dual_intr", 8'(intr), 8'h01);
    do_ack(8'h0A);
    check("dual_isr1", in_service, 8'h04);
    check("dual_pend1", pending, 8'h20);
    tick();
    check("dual_blocked", 8'(intr), 8'h00);
    do_eoi();
    check("dual_eoi1", in_service, 8'h00);
    check("dual_intr_lat", 8'(intr), 8'h00);
    tick();
    check("dual_intr2", 8'(intr), 8'h01);
    do_ack(8'h0D);
    check("dual_isr2", in_service, 8'h20);
    check("dual_pend2", pending, 8'h00);
    tick();
    do_eoi();
    check("dual_eoi2", in_service, 8'h00);

    // Nesting: 4 in service, 6 waits, 1 preempts.
    irq_lines = 8'h10;
    tick();
    irq_lines = 8'h00;
    tick();
    do_ack(8'h0C);
    check("nest_isr4", in_service, 8'h10);
    tick();
    irq_lines = 8'h40;
    tick();
    irq_lines = 8'h00;
    check("nest_pend6", pending, 8'h40);
    tick(2);
    check("nest_6_blocked", 8'(intr), 8'h00);
    irq_lines = 8'h02;
    tick();
    irq_lines = 8'h00;
    tick();
    check("nest_1_intr", 8'(intr), 8'h01);
    do_ack(8'h09);
    check("nest_isr12", in_service, 8'h12);
    check("nest_pend40", pending, 8'h40);
    tick();
    do_eoi();
    check("nest_eoi1", in_service, 8'h10);
    tick(2);
    check("nest_6_still", 8'(intr), 8'h00);
    do_eoi();
    check("nest_eoi4", in_service, 8'h00);
    tick();
    check("nest_6_intr", 8'(intr), 8'h01);
    do_ack(8'h0E);
    check("nest_isr6", in_service, 8'h40);
    tick();
    do_eoi();
    check("nest_eoi6", in_service, 8'h00);

    // Masked line is latched but not presented; masking in REQ withdraws intr.
    mask = 8'h01;
    irq_lines = 8'h01;
    tick();
    irq_lines = 8'h00;
    check("mask_pending", pending, 8'h01);
    tick(2);
    check("mask_intr", 8'(intr), 8'h00);
    mask = 8'h00;
    tick();
    check("unmask_intr", 8'(intr), 8'h01);
    mask = 8'h01;
    tick();
    check("req_mask_intr", 8'(intr), 8'h00);
    check("req_mask_pend", pending, 8'h01);
    mask = 8'h00;
    tick();
    check("req_unmask_intr", 8'(intr), 8'h01);
    do_ack(8'h08);
    check("mask_isr", in_service, 8'h01);
    tick();
    do_eoi();
    check("mask_eoi", in_service, 8'h00);

    // Spurious acknowledge: line 2 masked in the same cycle as inta.
    irq_lines = 8'h04;
    tick();
    irq_lines = 8'h00;
    tick();
    check("spur_intr", 8'(intr), 8'h01);
    mask = 8'h04;
    do_ack(8'h0F);
    check("spur_pending", pending, 8'h04);
    check("spur_isr", in_service, 8'h00);
    tick();
    check("spur_intr_low", 8'(intr), 8'h00);

    // Reset in the VECTOR cycle clears everything.
    mask = 8'h00;
    irq_lines = 8'h40;
    tick();
    irq_lines = 8'h00;
    check("pre_rst_intr", 8'(intr), 8'h01);
    do_ack(8'h0A);
    check("pre_rst_isr", in_service, 8'h04);
    check("pre_rst_pend", pending, 8'h40);
    #2;
    reset = 1'b1;
    tick();
    check("vrst_vv", 8'(vector_valid), 8'h00);
    check("vrst_intr", 8'(intr), 8'h00);
    check("vrst_vector", vector, 8'h00);
    check("vrst_pending", pending, 8'h00);
    check("vrst_isr", in_service, 8'h00);
    reset = 1'b0;
    tick(3);
    check("post_rst_intr", 8'(intr), 8'h00);
    check("sb_drained", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
